// File: rtl/stack_arb_if.sv
// ---------------------------------------------------------------------------
// stack_arb_if -- bundle between two requesters, the stack arbiter and the
// attached stack.
//
//   req0/req1         requester -> arbiter   request, held until ack/err
//   op0/op1           requester -> arbiter   0 = push, 1 = pop
//   wdata0/wdata1     requester -> arbiter   push data
//   ack0/ack1         arbiter -> requester   one-cycle completion pulse
//   err0/err1         arbiter -> requester   one-cycle refusal pulse
//   rdata             arbiter -> requester   last popped word
//   stk_push/stk_pop  arbiter -> stack       one-cycle strobes
//   stk_push_data     arbiter -> stack       data qualified by stk_push
//   stk_pop_data      stack -> arbiter       current top-of-stack word
//   stk_empty/full    stack -> arbiter       status flags
//
// Modports: slave = arbiter view, master = requester/stack (environment) view.
// ---------------------------------------------------------------------------
interface stack_arb_if #(
   parameter int WORD_BITS = 4
);
   logic                 req0;
   logic                 req1;
   logic                 op0;
   logic                 op1;
   logic [WORD_BITS-1:0] wdata0;
   logic [WORD_BITS-1:0] wdata1;
   logic                 ack0;
   logic                 ack1;
   logic                 err0;
   logic                 err1;
   logic [WORD_BITS-1:0] rdata;
   logic                 stk_push;
   logic                 stk_pop;
   logic [WORD_BITS-1:0] stk_push_data;
   logic [WORD_BITS-1:0] stk_pop_data;
   logic                 stk_empty;
   logic                 stk_full;

   modport slave (
      input  req0, req1, op0, op1, wdata0, wdata1,
      input  stk_pop_data, stk_empty, stk_full,
      output ack0, ack1, err0, err1, rdata,
      output stk_push, stk_pop, stk_push_data
   );

   modport master (
      output req0, req1, op0, op1, wdata0, wdata1,
      output stk_pop_data, stk_empty, stk_full,
      input  ack0, ack1, err0, err1, rdata,
      input  stk_push, stk_pop, stk_push_data
   );
endinterface

// File: rtl/stack_arb.sv
// ---------------------------------------------------------------------------
// stack_arb -- two-requester arbiter in front of a push/pop stack.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset; release is synchronised internally
//   bus   stack_arb_if.slave (requester handshakes and stack strobes)
//
// FSM IDLE -> ISSUE -> RESP for legal ops (strobe one cycle, then ack);
// IDLE -> RESP for refused ops (err, no strobe). Every output is a register.
//
// Optional build macro STACK_ARB_FIXED_PRI_EN: when defined, requester 0
// always wins ties; otherwise ties are resolved round-robin.
// ---------------------------------------------------------------------------
module stack_arb #(
   parameter int WORD_BITS = 4
) (
   input logic       clk,
   input logic       rst,
   stack_arb_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t               state, state_nxt;
   logic [1:0]           rst_sync;
   logic                 rst_ok;
   logic                 gnt_idx, gnt_idx_nxt;
   logic                 gnt_op, gnt_op_nxt;
   logic                 last_gnt, last_nxt;
   logic                 ack0_q, ack0_nxt;
   logic                 ack1_q, ack1_nxt;
   logic                 err0_q, err0_nxt;
   logic                 err1_q, err1_nxt;
   logic                 push_q, push_nxt;
   logic                 pop_q, pop_nxt;
   logic [WORD_BITS-1:0] push_data_q, push_data_nxt;
   logic [WORD_BITS-1:0] rdata_q, rdata_nxt;
   logic                 sel;
   logic                 sel_op;
   logic [WORD_BITS-1:0] sel_data;
   logic                 sel_legal;

   // Reset release passes two flops before the FSM may grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync <= '0;
      else      rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_ok = rst_sync[1];

   always_comb begin
`ifdef STACK_ARB_FIXED_PRI_EN
      sel = !bus.req0;
`else
      if (bus.req0 && bus.req1) sel = !last_gnt;
      else                      sel = bus.req1;
`endif
      sel_op    = sel ? bus.op1 : bus.op0;
      sel_data  = sel ? bus.wdata1 : bus.wdata0;
      sel_legal = sel_op ? !bus.stk_empty : !bus.stk_full;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         gnt_idx     <= 1'b0;
         gnt_op      <= 1'b0;
         last_gnt    <= 1'b1;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
         push_q      <= 1'b0;
         pop_q       <= 1'b0;
         push_data_q <= '0;
         rdata_q     <= '0;
      end else begin
         state       <= state_nxt;
         gnt_idx     <= gnt_idx_nxt;
         gnt_op      <= gnt_op_nxt;
         last_gnt    <= last_nxt;
         ack0_q      <= ack0_nxt;
         ack1_q      <= ack1_nxt;
         err0_q      <= err0_nxt;
         err1_q      <= err1_nxt;
         push_q      <= push_nxt;
         pop_q       <= pop_nxt;
         push_data_q <= push_data_nxt;
         rdata_q     <= rdata_nxt;
      end
   end

   // Outputs are decoded from the next state and registered, so strobes are
   // high during ISSUE and ack/err during RESP.
   always_comb begin
      state_nxt     = state;
      gnt_idx_nxt   = gnt_idx;
      gnt_op_nxt    = gnt_op;
      last_nxt      = last_gnt;
      ack0_nxt      = 1'b0;
      ack1_nxt      = 1'b0;
      err0_nxt      = 1'b0;
      err1_nxt      = 1'b0;
      push_nxt      = 1'b0;
      pop_nxt       = 1'b0;
      push_data_nxt = push_data_q;
      rdata_nxt     = rdata_q;
      case (state)
         IDLE: begin
            if (rst_ok && (bus.req0 || bus.req1)) begin
               gnt_idx_nxt = sel;
               gnt_op_nxt  = sel_op;
               if (sel_legal) begin
                  state_nxt = ISSUE;
                  push_nxt  = !sel_op;
                  pop_nxt   = sel_op;
                  if (!sel_op) push_data_nxt = sel_data;
               end else begin
                  state_nxt = RESP;
                  err0_nxt  = !sel;
                  err1_nxt  = sel;
               end
            end
         end
         ISSUE: begin
            // Top-of-stack is still the pre-pop word during the strobe cycle.
            state_nxt = RESP;
            if (gnt_op) rdata_nxt = bus.stk_pop_data;
            ack0_nxt  = !gnt_idx;
            ack1_nxt  = gnt_idx;
         end
         RESP: begin
            state_nxt = IDLE;
            last_nxt  = gnt_idx;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.ack0          = ack0_q;
   assign bus.ack1          = ack1_q;
   assign bus.err0          = err0_q;
   assign bus.err1          = err1_q;
   assign bus.rdata         = rdata_q;
   assign bus.stk_push      = push_q;
   assign bus.stk_pop       = pop_q;
   assign bus.stk_push_data = push_data_q;

endmodule
